// File: rtl/joy_serial_reader_if.sv
// Serial joystick bus: shift-register control lines out, serial data in,
// and the published joystick vectors with their frame strobe.
interface joy_serial_reader_if;
  logic        JOY_DATA;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic [11:0] joystick1;
  logic [11:0] joystick2;
  logic        frame_strobe;

  modport master (
    input  JOY_DATA,
    output JOY_CLK,
    output JOY_LOAD,
    output joystick1,
    output joystick2,
    output frame_strobe
  );

  modport slave (
    output JOY_DATA,
    input  JOY_CLK,
    input  JOY_LOAD,
    input  joystick1,
    input  joystick2,
    input  frame_strobe
  );
endinterface

// File: rtl/joy_serial_reader.sv
// Serial joystick front-end: clocks the external shift register, deserialises
// 24-bit frames and publishes both joystick vectors atomically per frame.
//
// state      | meaning
// ST_HOLD_LO | after reset, first half period with JOY_CLK low
// ST_HOLD_HI | second half period, JOY_CLK still held low
// ST_RUN     | JOY_CLK toggling, slots captured on rising edges
module joy_serial_reader #(
  parameter int CLK_DIV = 64,
  parameter bit FILTER  = 1'b1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  joy_serial_reader_if.master   joy
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] SLOT_LAST = 5'd25;

  typedef enum logic [1:0] {
    ST_HOLD_LO,
    ST_HOLD_HI,
    ST_RUN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_sync2;
  logic [7:0]  r_div;
  logic        r_joy_clk;
  logic        w_joy_clk_nxt;
  logic        w_wrap;
  logic        w_rise;
  logic [4:0]  r_slot;
  logic        r_load;
  logic [23:0] r_shadow;
  logic [23:0] r_prev;
  logic [11:0] r_joy1;
  logic [11:0] r_joy2;
  logic        r_frame_end;
  logic        r_strobe;
  logic        w_dst_valid;
  logic [4:0]  w_dst_idx;

  assign w_wrap = (r_div == DIV_LAST);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= ST_HOLD_LO;
      r_joy_clk <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_joy_clk <= w_joy_clk_nxt;
    end
  end

  // The first full JOY_CLK period after reset stays low; its closing wrap is
  // the first rising edge, which opens slot 0 instead of capturing.
  always_comb begin
    w_state_nxt   = r_state;
    w_joy_clk_nxt = r_joy_clk;
    w_rise        = 1'b0;
    case (r_state)
      ST_HOLD_LO: begin
        if (w_wrap) w_state_nxt = ST_HOLD_HI;
      end
      ST_HOLD_HI: begin
        if (w_wrap) begin
          w_state_nxt   = ST_RUN;
          w_joy_clk_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_wrap) begin
          w_joy_clk_nxt = ~r_joy_clk;
          w_rise        = ~r_joy_clk;
        end
      end
      default: w_state_nxt = ST_HOLD_LO;
    endcase
  end

  // Shadow bit index in {j2,j1}: j1 occupies 11:0, j2 occupies 23:12.
  always_comb begin
    w_dst_valid = 1'b1;
    w_dst_idx   = 5'd0;
    case (r_slot)
      5'd2:  w_dst_idx = 5'd8;
      5'd3:  w_dst_idx = 5'd6;
      5'd4:  w_dst_idx = 5'd5;
      5'd5:  w_dst_idx = 5'd4;
      5'd6:  w_dst_idx = 5'd3;
      5'd7:  w_dst_idx = 5'd2;
      5'd8:  w_dst_idx = 5'd1;
      5'd9:  w_dst_idx = 5'd0;
      5'd10: w_dst_idx = 5'd20;
      5'd11: w_dst_idx = 5'd18;
      5'd12: w_dst_idx = 5'd17;
      5'd13: w_dst_idx = 5'd16;
      5'd14: w_dst_idx = 5'd15;
      5'd15: w_dst_idx = 5'd14;
      5'd16: w_dst_idx = 5'd13;
      5'd17: w_dst_idx = 5'd12;
      5'd18: w_dst_idx = 5'd22;
      5'd19: w_dst_idx = 5'd23;
      5'd20: w_dst_idx = 5'd21;
      5'd21: w_dst_idx = 5'd19;
      5'd22: w_dst_idx = 5'd10;
      5'd23: w_dst_idx = 5'd11;
      5'd24: w_dst_idx = 5'd9;
      5'd25: w_dst_idx = 5'd7;
      default: w_dst_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_div       <= 8'd0;
      r_slot      <= 5'd0;
      r_load      <= 1'b1;
      r_shadow    <= '1;
      r_prev      <= '1;
      r_joy1      <= '1;
      r_joy2      <= '1;
      r_frame_end <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_sync1     <= joy.JOY_DATA;
      r_sync2     <= r_sync1;
      r_div       <= w_wrap ? 8'd0 : r_div + 8'd1;
      r_load      <= !((r_state == ST_RUN) && (r_slot == 5'd0));
      r_frame_end <= w_rise && (r_slot == SLOT_LAST);
      r_strobe    <= r_frame_end;
      if (w_rise) begin
        if (w_dst_valid) r_shadow[w_dst_idx] <= r_sync2;
        r_slot <= (r_slot == SLOT_LAST) ? 5'd0 : r_slot + 5'd1;
      end
      // Shadow is complete here; both vectors move together or not at all.
      if (r_frame_end) begin
        r_prev <= r_shadow;
        if ((FILTER == 1'b0) || (r_shadow == r_prev)) begin
          r_joy1 <= r_shadow[11:0];
          r_joy2 <= r_shadow[23:12];
        end
      end
    end
  end

  assign joy.JOY_CLK      = r_joy_clk;
  assign joy.JOY_LOAD     = r_load;
  assign joy.joystick1    = r_joy1;
  assign joy.joystick2    = r_joy2;
  assign joy.frame_strobe = r_strobe;

endmodule

// File: tb/tb_joy_serial_reader.sv
// Directed bench: two CLK_DIV=4 readers (unfiltered and filtered) share one
// serial stream; a CLK_DIV=64 reader checks default start-up timing.
module tb_joy_serial_reader;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic joy_data = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   abs_cyc  = 0;
  int   last_strobe = -1;
  int   rise_a = -1, load_a = -1, rise_c = -1, load_c = -1;

  always #5 clk_sys = ~clk_sys;

  joy_serial_reader_if if_a ();
  joy_serial_reader_if if_b ();
  joy_serial_reader_if if_c ();

  assign if_a.JOY_DATA = joy_data;
  assign if_b.JOY_DATA = joy_data;
  assign if_c.JOY_DATA = joy_data;

  joy_serial_reader #(.CLK_DIV(4),  .FILTER(1'b0)) dut_nf   (.clk_sys(clk_sys), .reset(reset), .joy(if_a));
  joy_serial_reader #(.CLK_DIV(4),  .FILTER(1'b1)) dut_f    (.clk_sys(clk_sys), .reset(reset), .joy(if_b));
  joy_serial_reader #(.CLK_DIV(64), .FILTER(1'b1)) dut_slow (.clk_sys(clk_sys), .reset(reset), .joy(if_c));

  always @(posedge clk_sys) begin
    cyc     <= reset ? 0 : cyc + 1;
    abs_cyc <= abs_cyc + 1;
  end

  always @(negedge clk_sys) begin
    if (reset) begin
      rise_a = -1; load_a = -1; rise_c = -1; load_c = -1;
    end else begin
      if (rise_a < 0 && if_a.JOY_CLK)   rise_a = cyc;
      if (load_a < 0 && !if_a.JOY_LOAD) load_a = cyc;
      if (rise_c < 0 && if_c.JOY_CLK)   rise_c = cyc;
      if (load_c < 0 && !if_c.JOY_LOAD) load_c = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle with JOY_CLK high.
  task automatic wait_rise();
    logic prev_clk;
    int   n;
    prev_clk = if_a.JOY_CLK;
    n = 0;
    forever begin
      @(negedge clk_sys);
      n++;
      if (if_a.JOY_CLK && !prev_clk) break;
      prev_clk = if_a.JOY_CLK;
      if (n > 40) begin
        check_eq("rise_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a_j1"},   32'(if_a.joystick1),    32'hFFF);
    check_eq({tag, "_a_j2"},   32'(if_a.joystick2),    32'hFFF);
    check_eq({tag, "_b_j1"},   32'(if_b.joystick1),    32'hFFF);
    check_eq({tag, "_b_j2"},   32'(if_b.joystick2),    32'hFFF);
    check_eq({tag, "_a_load"}, 32'(if_a.JOY_LOAD),     32'd1);
    check_eq({tag, "_a_clk"},  32'(if_a.JOY_CLK),      32'd0);
    check_eq({tag, "_c_load"}, 32'(if_c.JOY_LOAD),     32'd1);
    check_eq({tag, "_c_clk"},  32'(if_c.JOY_CLK),      32'd0);
    check_eq({tag, "_a_strb"}, 32'(if_a.frame_strobe), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [25:0] low_mask,
                           input logic [11:0] a1, input logic [11:0] a2,
                           input logic [11:0] b1, input logic [11:0] b2);
    for (int s = 0; s < 26; s++) begin
      joy_data = !low_mask[s];
      wait_rise();
    end
    joy_data = 1'b1;
    check_eq({tag, "_strb_early"}, 32'(if_a.frame_strobe), 32'd0);
    @(negedge clk_sys);
    check_eq({tag, "_a_strb"}, 32'(if_a.frame_strobe), 32'd1);
    check_eq({tag, "_b_strb"}, 32'(if_b.frame_strobe), 32'd1);
    check_eq({tag, "_a_j1"},   32'(if_a.joystick1), 32'(a1));
    check_eq({tag, "_a_j2"},   32'(if_a.joystick2), 32'(a2));
    check_eq({tag, "_b_j1"},   32'(if_b.joystick1), 32'(b1));
    check_eq({tag, "_b_j2"},   32'(if_b.joystick2), 32'(b2));
    if (last_strobe >= 0)
      check_eq({tag, "_period"}, 32'(abs_cyc - last_strobe), 32'd208);
    last_strobe = abs_cyc;
    @(negedge clk_sys);
    check_eq({tag, "_strb_one"}, 32'(if_a.frame_strobe), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    joy_data = 1'b1;
    repeat (10) @(negedge clk_sys);
    check_reset_outputs("rst");
    reset = 1'b0;
    wait_rise();

    run_frame("idle0",  26'd0,        12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    check_eq("start_rise_a", 32'(rise_a), 32'd8);
    check_eq("start_load_a", 32'(load_a), 32'd9);
    check_eq("start_rise_c", 32'(rise_c), 32'd128);
    check_eq("start_load_c", 32'(load_c), 32'd129);
    run_frame("slot9",  26'd1 << 9,   12'hFFE, 12'hFFF, 12'hFFF, 12'hFFF);
    run_frame("slot19", 26'd1 << 19,  12'hFFF, 12'h7FF, 12'hFFF, 12'hFFF);
    run_frame("slot25", 26'd1 << 25,  12'hF7F, 12'hFFF, 12'hFFF, 12'hFFF);
    run_frame("slot10", 26'd1 << 10,  12'hFFF, 12'hEFF, 12'hFFF, 12'hFFF);
    run_frame("fA",     26'd1 << 2,   12'hEFF, 12'hFFF, 12'hFFF, 12'hFFF);
    run_frame("fB1",    26'd1 << 3,   12'hFBF, 12'hFFF, 12'hFFF, 12'hFFF);
    run_frame("fB2",    26'd1 << 3,   12'hFBF, 12'hFFF, 12'hFBF, 12'hFFF);
    run_frame("idle1",  26'd0,        12'hFFF, 12'hFFF, 12'hFBF, 12'hFFF);
    run_frame("idle2",  26'd0,        12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    run_frame("glitch", 26'd1 << 23,  12'h7FF, 12'hFFF, 12'hFFF, 12'hFFF);
    run_frame("idle3",  26'd0,        12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    run_frame("pre1",   26'd1 << 9,   12'hFFE, 12'hFFF, 12'hFFF, 12'hFFF);
    run_frame("pre2",   26'd1 << 9,   12'hFFE, 12'hFFF, 12'hFFE, 12'hFFF);

    // Partial frame: reset lands while slot 12 is pending.
    for (int s = 0; s < 12; s++) begin
      joy_data = (s != 9);
      wait_rise();
    end
    joy_data = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    check_reset_outputs("midrst");
    reset = 1'b0;
    last_strobe = -1;
    wait_rise();

    run_frame("post1",  26'd1 << 9,   12'hFFE, 12'hFFF, 12'hFFF, 12'hFFF);
    check_eq("post_rise_a", 32'(rise_a), 32'd8);
    check_eq("post_load_a", 32'(load_a), 32'd9);
    run_frame("post2",  26'd1 << 9,   12'hFFE, 12'hFFF, 12'hFFE, 12'hFFF);
    check_eq("post_rise_c", 32'(rise_c), 32'd128);
    check_eq("post_load_c", 32'(load_c), 32'd129);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
